// File: rtl/microbot_nav_controller_pwm.sv
// Microbot navigation controller: debounced sensors, five-state steering FSM,
// PWM speed control and dead-time on every direction change.
module microbot_nav_controller_pwm #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int PWM_BITS        = 8,
  parameter int MIN_DWELL       = 16,
  parameter int REVERSE_CYCLES  = 64,
  parameter int DEAD_CYCLES     = 2
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                enable,
  input  logic [2:0]          sensors,
  input  logic [PWM_BITS-1:0] speed_fwd,
  input  logic [PWM_BITS-1:0] speed_turn,
  output logic [1:0]          motor_a,
  output logic [1:0]          motor_b,
  output logic [2:0]          state_o
);

  typedef enum logic [2:0] {
    ST_STBY = 3'd0,
    ST_FWD  = 3'd1,
    ST_TR   = 3'd2,
    ST_TL   = 3'd3,
    ST_REV  = 3'd4
  } state_e;

  localparam int DBW  = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int DBL  = (DEBOUNCE_CYCLES > 0) ? DEBOUNCE_CYCLES - 1 : 0;
  localparam int DWL  = (MIN_DWELL > 0) ? MIN_DWELL - 1 : 0;
  localparam int RVL  = (REVERSE_CYCLES > 0) ? REVERSE_CYCLES - 1 : 0;
  localparam int TMAX = (MIN_DWELL > REVERSE_CYCLES) ? MIN_DWELL : REVERSE_CYCLES;
  localparam int TW   = $clog2(TMAX + 2);
  localparam int DEW  = $clog2(DEAD_CYCLES + 2);

  localparam logic [DBW-1:0] DB_LAST = DBW'(DBL);
  localparam logic [TW-1:0]  DW_TH   = TW'(DWL);
  localparam logic [TW-1:0]  RV_TH   = TW'(RVL);
  localparam logic [TW-1:0]  T_SAT   = TW'(TMAX);
  localparam logic [DEW-1:0] DEAD_LD = DEW'(DEAD_CYCLES);

  logic [2:0][DBW-1:0] db_cnt_q, db_cnt_d;
  logic [2:0]          filt_q, filt_d;
  state_e              state_q, state_d, tgt;
  logic [TW-1:0]       tmr_q, tmr_d;
  logic [DEW-1:0]      dead_q, dead_d;
  logic [PWM_BITS-1:0] pwm_q, pwm_d;
  logic [3:0]          motor_q, motor_d;
  logic [PWM_BITS-1:0] duty;
  logic                pwm_on;
  logic                chg;
  logic                f, l, r;

  function automatic logic [3:0] dir_map(input state_e s);
    logic [3:0] m;
    unique case (s)
      ST_FWD:  m = 4'b1010;
      ST_TR:   m = 4'b1001;
      ST_TL:   m = 4'b0110;
      ST_REV:  m = 4'b0101;
      default: m = 4'b0000;
    endcase
    return m;
  endfunction

  always_comb begin
    filt_d   = filt_q;
    db_cnt_d = '0;
    for (int i = 0; i < 3; i++) begin
      if (sensors[i] != filt_q[i]) begin
        if (db_cnt_q[i] == DB_LAST) begin
          filt_d[i] = sensors[i];
        end else begin
          db_cnt_d[i] = db_cnt_q[i] + 1'b1;
        end
      end
    end
  end

  assign f = filt_q[2];
  assign l = filt_q[1];
  assign r = filt_q[0];

  always_comb begin
    tgt = ST_FWD;
    unique case (1'b1)
      (f & l & r):   tgt = ST_REV;
      (l & ~r):      tgt = ST_TR;
      (~l & r):      tgt = ST_TL;
      (f & ~l & ~r): tgt = ST_TR;
      default:       tgt = ST_FWD;
    endcase
  end

  always_comb begin
    state_d = state_q;
    if (!enable) begin
      state_d = ST_STBY;
    end else begin
      unique case (state_q)
        ST_STBY: state_d = tgt;
        ST_FWD, ST_TR, ST_TL: begin
          if (tmr_q >= DW_TH && tgt != state_q) state_d = tgt;
        end
        ST_REV: begin
          if (tmr_q >= RV_TH) state_d = (tgt == ST_REV) ? ST_TR : tgt;
        end
        default: state_d = ST_STBY;
      endcase
    end
  end

  assign chg = (state_d != state_q);

  always_comb begin
    tmr_d = '0;
    if (!chg) tmr_d = (tmr_q == T_SAT) ? tmr_q : tmr_q + 1'b1;
  end

  always_comb begin
    dead_d = '0;
    if (chg) begin
      dead_d = DEAD_LD;
    end else if (dead_q != '0) begin
      dead_d = dead_q - 1'b1;
    end
  end

  // Gate on the post-edge state so a new direction never overlaps the old one
  assign duty    = (state_d == ST_FWD || state_d == ST_REV) ? speed_fwd : speed_turn;
  assign pwm_on  = (pwm_q < duty);
  assign pwm_d   = pwm_q + 1'b1;
  assign motor_d = (dead_d != '0) ? 4'b0000 : (dir_map(state_d) & {4{pwm_on}});

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      db_cnt_q <= '0;
      filt_q   <= '0;
      state_q  <= ST_STBY;
      tmr_q    <= '0;
      dead_q   <= '0;
      pwm_q    <= '0;
      motor_q  <= '0;
    end else begin
      db_cnt_q <= db_cnt_d;
      filt_q   <= filt_d;
      state_q  <= state_d;
      tmr_q    <= tmr_d;
      dead_q   <= dead_d;
      pwm_q    <= pwm_d;
      motor_q  <= motor_d;
    end
  end

  assign motor_a = motor_q[3:2];
  assign motor_b = motor_q[1:0];
  assign state_o = state_q;

endmodule

// File: tb/tb_microbot_nav_controller_pwm.sv
// Bench for microbot_nav_controller_pwm: directed scenarios plus random
// stimulus checked every cycle against a behavioural model.
module tb_microbot_nav_controller_pwm;

  localparam int D  = 4;
  localparam int PB = 4;
  localparam int MD = 8;
  localparam int RC = 16;
  localparam int DC = 2;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          enable = 1'b1;
  logic [2:0]    sensors = 3'b000;
  logic [PB-1:0] speed_fwd = 4'd15;
  logic [PB-1:0] speed_turn = 4'd15;
  logic [1:0]    motor_a, motor_b;
  logic [2:0]    state_o;

  microbot_nav_controller_pwm #(
    .DEBOUNCE_CYCLES(D),
    .PWM_BITS(PB),
    .MIN_DWELL(MD),
    .REVERSE_CYCLES(RC),
    .DEAD_CYCLES(DC)
  ) dut (
    .clk(clk),
    .reset(reset),
    .enable(enable),
    .sensors(sensors),
    .speed_fwd(speed_fwd),
    .speed_turn(speed_turn),
    .motor_a(motor_a),
    .motor_b(motor_b),
    .state_o(state_o)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // target per filtered {f,l,r}, and direction per state
  logic [2:0] TGT [8] = '{3'd1, 3'd3, 3'd2, 3'd1, 3'd2, 3'd3, 3'd2, 3'd4};
  logic [1:0] MAPA [5] = '{2'b00, 2'b10, 2'b10, 2'b01, 2'b01};
  logic [1:0] MAPB [5] = '{2'b00, 2'b10, 2'b01, 2'b10, 2'b01};

  logic [2:0]    s_sens;
  logic          s_en, s_rst;
  logic [PB-1:0] s_sf, s_st;

  always @(posedge clk) begin
    s_sens <= sensors;
    s_en   <= enable;
    s_sf   <= speed_fwd;
    s_st   <= speed_turn;
    s_rst  <= reset;
  end

  logic [2:0]   m_st;
  logic [2:0]   m_filt;
  logic [D-1:0] m_hist [3];
  logic [1:0]   m_a, m_b;
  int           m_tin, m_since, m_pwm;

  task automatic model_reset();
    m_st    = 3'd0;
    m_filt  = 3'b000;
    for (int i = 0; i < 3; i++) m_hist[i] = '0;
    m_a     = 2'b00;
    m_b     = 2'b00;
    m_tin   = 0;
    m_since = DC;
    m_pwm   = 0;
  endtask

  task automatic model_step();
    logic [2:0] tgt, nx;
    logic [PB-1:0] duty;
    bit on;
    tgt = TGT[m_filt];
    if (!s_en) nx = 3'd0;
    else if (m_st == 3'd0) nx = tgt;
    else if (m_st == 3'd4) nx = (m_tin >= RC - 1) ? ((tgt == 3'd4) ? 3'd2 : tgt) : 3'd4;
    else nx = (m_tin >= MD - 1 && tgt != m_st) ? tgt : m_st;
    if (nx != m_st) begin
      m_tin = 0;
      m_since = 0;
    end else begin
      m_tin++;
      if (m_since < 1000) m_since++;
    end
    duty = (nx == 3'd1 || nx == 3'd4) ? s_sf : s_st;
    on = (m_pwm < int'(duty));
    m_a = (m_since < DC || !on) ? 2'b00 : MAPA[nx];
    m_b = (m_since < DC || !on) ? 2'b00 : MAPB[nx];
    m_st = nx;
    m_pwm = (m_pwm + 1) % (1 << PB);
    // filtered bit flips once the last D raw samples all disagree with it
    for (int i = 0; i < 3; i++) begin
      m_hist[i] = {m_hist[i][D-2:0], s_sens[i]};
      if (m_hist[i] == {D{~m_filt[i]}}) m_filt[i] = ~m_filt[i];
    end
  endtask

  initial begin
    model_reset();
    forever begin
      @(negedge clk);
      if (reset || s_rst) model_reset();
      else model_step();
      n_tests++;
      if (state_o != m_st || motor_a != m_a || motor_b != m_b) begin
        n_fail++;
        $display("FAIL model t=%0t: got st=%0d a=%b b=%b expected st=%0d a=%b b=%b",
                 $time, state_o, motor_a, motor_b, m_st, m_a, m_b);
      end
      n_tests++;
      if (motor_a == 2'b11 || motor_b == 2'b11) begin
        n_fail++;
        $display("FAIL shoot_through t=%0t: got a=%b b=%b expected no 11",
                 $time, motor_a, motor_b);
      end
    end
  end

  task automatic chk(input string nm, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s t=%0t: got %0d expected %0d", nm, $time, act, exp);
    end
  endtask

  task automatic wait_state(input int s, input int maxc, input string nm, output int k);
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (int'(state_o) != s && k < maxc);
    chk(nm, int'(state_o), s);
  endtask

  int k, cnt;

  initial begin
    repeat (3) @(negedge clk);
    chk("reset_state", int'(state_o), 0);
    chk("reset_motors", int'({motor_a, motor_b}), 0);
    reset = 1'b0;

    // 1: STANDBY -> FORWARD, dead-time, PWM gap at count 15
    @(negedge clk);
    chk("fwd_entry", int'(state_o), 1);
    chk("dead_0", int'(motor_a), 0);
    @(negedge clk);
    chk("dead_1", int'(motor_a), 0);
    @(negedge clk);
    chk("fwd_on_a", int'(motor_a), 2);
    chk("fwd_on_b", int'(motor_b), 2);
    repeat (13) @(negedge clk);
    chk("pwm_cnt15_off", int'(motor_a), 0);
    @(negedge clk);
    chk("pwm_wrap_on", int'(motor_a), 2);

    // 2: short glitch ignored, held left obstacle turns right
    sensors = 3'b010;
    repeat (2) @(negedge clk);
    sensors = 3'b000;
    repeat (4) @(negedge clk);
    chk("glitch_ignored", int'(state_o), 1);
    sensors = 3'b010;
    wait_state(2, 20, "turn_right", k);
    chk("turn_right_latency", k, 5);

    // 3: back to FORWARD, then right obstacle at dwell 3
    sensors = 3'b000;
    wait_state(1, 30, "back_fwd", k);
    repeat (3) @(negedge clk);
    sensors = 3'b001;
    wait_state(3, 20, "turn_left", k);
    chk("turn_left_latency", k, 5);

    // 4: REVERSE lasts exactly RC cycles, exits to TURN_RIGHT
    sensors = 3'b111;
    wait_state(4, 40, "reverse_entry", k);
    cnt = 1;
    do begin
      @(negedge clk);
      if (state_o == 3'd4) cnt++;
    end while (state_o == 3'd4 && cnt < 40);
    chk("reverse_len", cnt, RC);
    chk("reverse_exit", int'(state_o), 2);

    // 5: zero turn duty, half forward duty
    sensors = 3'b001;
    wait_state(3, 40, "tl_for_duty", k);
    speed_turn = 4'd0;
    cnt = 0;
    repeat (20) begin
      @(negedge clk);
      if ({motor_a, motor_b} != 4'b0000) cnt++;
    end
    chk("turn_duty0", cnt, 0);
    sensors = 3'b000;
    speed_fwd = 4'd8;
    wait_state(1, 40, "fwd_for_duty", k);
    repeat (2) @(negedge clk);
    cnt = 0;
    repeat (16) begin
      @(negedge clk);
      if (motor_a == 2'b10) cnt++;
    end
    chk("fwd_duty8", cnt, 8);

    // 6: enable drop mid-REVERSE, async reset mid-FORWARD
    speed_fwd = 4'd15;
    speed_turn = 4'd15;
    sensors = 3'b111;
    wait_state(4, 40, "rev_for_en", k);
    repeat (3) @(negedge clk);
    enable = 1'b0;
    @(negedge clk);
    chk("en_drop_state", int'(state_o), 0);
    chk("en_drop_motors", int'({motor_a, motor_b}), 0);
    enable = 1'b1;
    sensors = 3'b000;
    wait_state(1, 40, "fwd_for_rst", k);
    repeat (5) @(negedge clk);
    #2 reset = 1'b1;
    #1;
    chk("async_rst_motors", int'({motor_a, motor_b}), 0);
    chk("async_rst_state", int'(state_o), 0);
    repeat (2) @(negedge clk);
    #2 reset = 1'b0;
    @(negedge clk);
    chk("post_rst_fwd", int'(state_o), 1);

    // random traffic, model compare runs every cycle
    for (int i = 0; i < 4000; i++) begin
      @(negedge clk);
      #2;
      if (reset) reset = 1'b0;
      else if ($urandom_range(599) == 0) reset = 1'b1;
      if ($urandom_range(5) == 0) sensors = 3'($urandom_range(7));
      if (!enable) enable = ($urandom_range(3) == 0);
      else if ($urandom_range(79) == 0) enable = 1'b0;
      if ($urandom_range(19) == 0) speed_fwd = 4'($urandom_range(15));
      if ($urandom_range(19) == 0) speed_turn = 4'($urandom_range(15));
    end
    reset = 1'b0;
    repeat (2) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
